reaction_fsm: RTL and testbench

- Core control stage of the reaction timer.
- Sits directly downstream of the clock-divider stage and consumes its timebase as a 1 ms single-cycle enable (`tick`) in the system clock domain.
- Sequences a round: random wait, stimulus LED on, then millisecond counting until the react button is pressed.
- Produces a latched reaction time for the display stage, a timeout flag, and a too-early (foul) flag.

---
 rtl/reaction_fsm.sv | 199 +++++++++++++++++++
 tb/tb_reaction_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_fsm.sv
// Reaction-timer control stage: random wait, stimulus LED, millisecond count until the react press.
// Optional best-score tracking is compiled in with the BEST_SCORE_EN macro.
module reaction_fsm #(
    parameter int unsigned MIN_WAIT_MS = 1000,
    parameter int unsigned RAND_BITS   = 11,
    parameter int unsigned MAX_MS      = 9999,
    parameter int unsigned CNT_W       = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start_btn,
    input  logic             react_btn,
    output logic             led,
    output logic [CNT_W-1:0] reaction_ms,
    output logic             result_valid,
    output logic             timeout,
    output logic             too_early,
    output logic             busy
`ifdef BEST_SCORE_EN
    ,
    output logic [CNT_W-1:0] best_ms
`endif
);

    localparam int unsigned WAIT_W    = $clog2(MIN_WAIT_MS + (1 << RAND_BITS));
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ARMED,
        ST_DONE,
        ST_FOUL
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [CNT_W-1:0]   reaction_q, reaction_d;
    logic               result_valid_q, result_valid_d;
    logic               timeout_q, timeout_d;
    logic               too_early_q, too_early_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
`ifdef BEST_SCORE_EN
    logic [CNT_W-1:0]   best_q, best_d;
`endif

    // Bit 0 is the start button, bit 1 the react button.
    logic [1:0] sync1_q, sync2_q, dly_q;
    logic       start_evt_c, react_evt_c;
    logic [WAIT_W-1:0] wait_load_c;

    // Two-flop synchroniser plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            dly_q   <= 2'b00;
        end else begin
            sync1_q <= {react_btn, start_btn};
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign start_evt_c = sync2_q[0] & ~dly_q[0];
    assign react_evt_c = sync2_q[1] & ~dly_q[1];

    // Galois LFSR, taps 16,14,13,11; free-running and never zero from a non-zero seed.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    assign wait_load_c = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr_q[RAND_BITS-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            lfsr_q         <= LFSR_SEED;
            wait_cnt_q     <= '0;
            ms_cnt_q       <= '0;
            reaction_q     <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            too_early_q    <= 1'b0;
            led_q          <= 1'b0;
            busy_q         <= 1'b0;
`ifdef BEST_SCORE_EN
            best_q         <= CNT_W'(MAX_MS);
`endif
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            wait_cnt_q     <= wait_cnt_d;
            ms_cnt_q       <= ms_cnt_d;
            reaction_q     <= reaction_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
            too_early_q    <= too_early_d;
            led_q          <= led_d;
            busy_q         <= busy_d;
`ifdef BEST_SCORE_EN
            best_q         <= best_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        ms_cnt_d       = ms_cnt_q;
        reaction_d     = reaction_q;
        result_valid_d = 1'b0;
        timeout_d      = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_evt_c) begin
                    wait_cnt_d = wait_load_c;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // React beats a coincident tick; the counter holds at 1 on the final tick.
                if (react_evt_c) begin
                    state_d = ST_FOUL;
                end else if (tick) begin
                    if (wait_cnt_q <= WAIT_W'(1)) begin
                        ms_cnt_d = '0;
                        state_d  = ST_ARMED;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                    end
                end
            end
            ST_ARMED: begin
                // React latches the pre-increment count even when a tick coincides.
                if (react_evt_c) begin
                    reaction_d     = ms_cnt_q;
                    result_valid_d = 1'b1;
                    timeout_d      = 1'b0;
                    state_d        = ST_DONE;
                end else if (tick) begin
                    if (ms_cnt_q >= CNT_W'(MAX_MS - 1)) begin
                        ms_cnt_d       = CNT_W'(MAX_MS);
                        reaction_d     = CNT_W'(MAX_MS);
                        result_valid_d = 1'b1;
                        timeout_d      = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        ms_cnt_d = ms_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (start_evt_c) begin
                    timeout_d  = 1'b0;
                    wait_cnt_d = wait_load_c;
                    state_d    = ST_WAIT;
                end
            end
            ST_FOUL: begin
                if (start_evt_c) begin
                    wait_cnt_d = wait_load_c;
                    state_d    = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_d       = (state_d == ST_ARMED);
        busy_d      = (state_d == ST_WAIT) || (state_d == ST_ARMED);
        too_early_d = (state_d == ST_FOUL);

`ifdef BEST_SCORE_EN
        best_d = best_q;
        if (result_valid_d && !timeout_d && (reaction_d < best_q)) begin
            best_d = reaction_d;
        end
`endif
    end

    assign led          = led_q;
    assign reaction_ms  = reaction_q;
    assign result_valid = result_valid_q;
    assign timeout      = timeout_q;
    assign too_early    = too_early_q;
    assign busy         = busy_q;
`ifdef BEST_SCORE_EN
    assign best_ms      = best_q;
`endif

endmodule

// File: tb/tb_reaction_fsm.sv
// Scoreboard bench for reaction_fsm: stimulus pushes expected results, a monitor checks each result_valid.
module tb_reaction_fsm;

    localparam int unsigned CNT_W  = 14;
    localparam int unsigned MAX_MS = 9999;

    logic             clk;
    logic             rst;
    logic             tick;
    logic             start_btn;
    logic             react_btn;
    logic             led;
    logic [CNT_W-1:0] reaction_ms;
    logic             result_valid;
    logic             timeout;
    logic             too_early;
    logic             busy;
`ifdef BEST_SCORE_EN
    logic [CNT_W-1:0] best_ms;
`endif

    reaction_fsm #(
        .MIN_WAIT_MS(20),
        .RAND_BITS  (4),
        .MAX_MS     (MAX_MS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start_btn   (start_btn),
        .react_btn   (react_btn),
        .led         (led),
        .reaction_ms (reaction_ms),
        .result_valid(result_valid),
        .timeout     (timeout),
        .too_early   (too_early),
        .busy        (busy)
`ifdef BEST_SCORE_EN
        ,
        .best_ms     (best_ms)
`endif
    );

    typedef struct packed {
        logic [CNT_W-1:0] ms;
        logic             to;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tick_period = 10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every result_valid cycle must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got ms=%0d timeout=%0b expected no result", reaction_ms, timeout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_ms", 32'(reaction_ms), 32'(e.ms));
                chk("result_timeout", 32'(timeout), 32'(e.to));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (tick_period - 1) step();
    endtask

    // Raw press is acted on at the third edge; afterwards the button is released and the sync drains.
    task automatic press(input logic s, input logic r);
        start_btn = s;
        react_btn = r;
        repeat (3) step();
        start_btn = 1'b0;
        react_btn = 1'b0;
        repeat (3) step();
    endtask

    task automatic wait_led();
        int g = 0;
        while (!led && g < 200) begin
            tick_once();
            g++;
        end
        chk("led_rise", 32'(led), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_led"}, 32'(led), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_reaction_ms"}, 32'(reaction_ms), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_too_early"}, 32'(too_early), 32'd0);
        chk({tag, "_lfsr"}, 32'(dut.lfsr_q), 32'h0000ACE1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        start_btn = 1'b0;
        react_btn = 1'b0;
        repeat (2) step();
        chk_reset("por");
        rst = 1'b0;
        step();

        // Normal round: react 250 ticks after the LED comes on.
        press(1'b1, 1'b0);
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_led_in_wait", 32'(led), 32'd0);
        wait_led();
        repeat (250) tick_once();
        exp_q.push_back('{ms: CNT_W'(250), to: 1'b0});
        press(1'b0, 1'b1);
        chk("a_reaction", 32'(reaction_ms), 32'd250);
        chk("a_led_off", 32'(led), 32'd0);
        chk("a_busy_off", 32'(busy), 32'd0);
        chk("a_timeout", 32'(timeout), 32'd0);
`ifdef BEST_SCORE_EN
        chk("a_best", 32'(best_ms), 32'd250);
`endif
        press(1'b0, 1'b1);
        chk("done_react_ignored", 32'(reaction_ms), 32'd250);

        // Foul: react during the random wait.
        press(1'b1, 1'b0);
        repeat (2) tick_once();
        press(1'b0, 1'b1);
        chk("b_too_early", 32'(too_early), 32'd1);
        chk("b_led", 32'(led), 32'd0);
        chk("b_busy", 32'(busy), 32'd0);
        chk("b_reaction_held", 32'(reaction_ms), 32'd250);
        repeat (40) tick_once();
        chk("b_led_still_off", 32'(led), 32'd0);
        press(1'b1, 1'b0);
        chk("b_too_early_clr", 32'(too_early), 32'd0);
        chk("b_busy_restart", 32'(busy), 32'd1);

        // Reset mid-ARMED at ms_cnt=37.
        wait_led();
        repeat (37) tick_once();
        rst = 1'b1;
        repeat (2) step();
        chk_reset("mid");
`ifdef BEST_SCORE_EN
        chk("mid_best", 32'(best_ms), 32'(MAX_MS));
`endif
        rst = 1'b0;
        step();

        // Timeout: no react, ticks every clk to keep the run short.
        tick_period = 1;
        press(1'b1, 1'b0);
        wait_led();
        exp_q.push_back('{ms: CNT_W'(MAX_MS), to: 1'b1});
        repeat (MAX_MS - 1) tick_once();
        chk("c_led_before_sat", 32'(led), 32'd1);
        chk("c_timeout_before_sat", 32'(timeout), 32'd0);
        tick_once();
        chk("c_timeout", 32'(timeout), 32'd1);
        chk("c_reaction", 32'(reaction_ms), 32'(MAX_MS));
        chk("c_led_off", 32'(led), 32'd0);
        chk("c_busy_off", 32'(busy), 32'd0);
`ifdef BEST_SCORE_EN
        chk("c_best_unchanged", 32'(best_ms), 32'(MAX_MS));
`endif

        // React event lands on the same edge as the tick at ms_cnt=100.
        tick_period = 10;
        press(1'b1, 1'b0);
        chk("d_timeout_clr", 32'(timeout), 32'd0);
        wait_led();
        repeat (100) tick_once();
        exp_q.push_back('{ms: CNT_W'(100), to: 1'b0});
        react_btn = 1'b1;
        repeat (2) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        react_btn = 1'b0;
        repeat (3) step();
        chk("d_reaction", 32'(reaction_ms), 32'd100);
        chk("d_busy_off", 32'(busy), 32'd0);
`ifdef BEST_SCORE_EN
        chk("d_best", 32'(best_ms), 32'd100);
`endif

        // Start and react in the same cycle from DONE: start wins.
        press(1'b1, 1'b1);
        chk("e_busy", 32'(busy), 32'd1);
        chk("e_too_early", 32'(too_early), 32'd0);
        chk("e_led", 32'(led), 32'd0);

        repeat (5) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
